// File: rtl/conv_acc_pkg.sv
// conv_acc_pkg: shared types and default widths for the conv accumulator /
// requantiser slice.
//   PROD_W  - multiplier product width
//   ACC_W   - accumulator width
//   OUT_W   - output activation width
//   CNT_W   - length / count field width
//   SHIFT_W - width of the requant shift field
//   state_t - control FSM states
package conv_acc_pkg;

  localparam int unsigned PROD_W  = 29;
  localparam int unsigned ACC_W   = 40;
  localparam int unsigned OUT_W   = 8;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned SHIFT_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    RND,
    OUT
  } state_t;

endpackage

// File: rtl/conv_acc_requant_if.sv
// conv_acc_requant_if: product input stream and activation output stream.
//   s_valid/s_ready/s_data        - product stream into the accumulator
//   m_valid/m_ready/m_data/m_sat  - activation stream out of the requantiser
// Modports:
//   slave  - the accumulator block (consumes products, produces activations)
//   master - the surrounding logic (produces products, consumes activations)
interface conv_acc_requant_if
  import conv_acc_pkg::*;
#(
  parameter int unsigned PROD_W = conv_acc_pkg::PROD_W,
  parameter int unsigned OUT_W  = conv_acc_pkg::OUT_W
);

  logic              s_valid;
  logic              s_ready;
  logic [PROD_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [OUT_W-1:0]  m_data;
  logic              m_sat;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_sat
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_sat
  );

endinterface

// File: rtl/conv_acc_requant_round_sat.sv
// conv_round_sat: combinational round-half-up, right shift and saturation of
// an accumulator value to an unsigned activation.
//   acc    - accumulated sum
//   shift  - right-shift amount (already limited to ACC_W-1)
//   sat_in - accumulator already clipped for this pixel
//   data   - rounded, shifted, saturated activation
//   sat    - activation clipped (sat_in or output range overflow)
module conv_round_sat #(
  parameter int unsigned ACC_W   = 40,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned SHIFT_W = 6
) (
  input  logic [ACC_W-1:0]   acc,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               sat_in,
  output logic [OUT_W-1:0]   data,
  output logic               sat
);

  logic [ACC_W:0] half;
  logic [ACC_W:0] rnd;
  logic [ACC_W:0] q;

  always_comb begin
    half = '0;
    if (shift != '0) begin
      half = (ACC_W+1)'(1) << (shift - SHIFT_W'(1));
    end
    // one extra bit so the rounding increment can never wrap
    rnd = {1'b0, acc} + half;
    q   = rnd >> shift;
    if (|q[ACC_W:OUT_W]) begin
      data = '1;
      sat  = 1'b1;
    end else begin
      data = q[OUT_W-1:0];
      sat  = sat_in;
    end
  end

endmodule

// File: rtl/conv_acc_requant.sv
// conv_acc_requant: accumulates cfg_len unsigned products per output pixel
// starting from cfg_bias, then rounds, shifts and saturates each sum into an
// OUT_W-bit activation; cfg_num activations are emitted per start command.
//   ap_clk, ap_rst_n  - clock, asynchronous active-low reset
//   start             - command pulse, sampled only when idle
//   cfg_len, cfg_num  - products per output, outputs per command (nonzero)
//   cfg_shift         - requant right shift (values >= ACC_W act as ACC_W-1)
//   cfg_bias          - initial accumulator value per pixel
//   bus               - product stream in, activation stream out
//   busy              - command in progress
//   done              - one-cycle pulse after the last activation handshake
//   err               - one-cycle pulse on a start with a zero len or num
module conv_acc_requant
  import conv_acc_pkg::*;
#(
  parameter int unsigned PROD_W = conv_acc_pkg::PROD_W,
  parameter int unsigned ACC_W  = conv_acc_pkg::ACC_W,
  parameter int unsigned OUT_W  = conv_acc_pkg::OUT_W,
  parameter int unsigned CNT_W  = conv_acc_pkg::CNT_W
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_num,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic [ACC_W-1:0]   cfg_bias,
  conv_acc_requant_if.slave  bus,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t             state;
  logic [CNT_W-1:0]   len_r;
  logic [CNT_W-1:0]   num_r;
  logic [SHIFT_W-1:0] shift_r;
  logic [ACC_W-1:0]   bias_r;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   beat_cnt;
  logic [CNT_W-1:0]   out_cnt;
  logic               sat_acc;
  logic               s_ready_r;
  logic               m_valid_r;
  logic [OUT_W-1:0]   m_data_r;
  logic               m_sat_r;

  logic [ACC_W:0]     sum;
  logic               s_hs;
  logic [OUT_W-1:0]   rs_data;
  logic               rs_sat;

  assign sum  = {1'b0, acc} + {{(ACC_W+1-PROD_W){1'b0}}, bus.s_data};
  assign s_hs = bus.s_valid && s_ready_r;

  assign bus.s_ready = s_ready_r;
  assign bus.m_valid = m_valid_r;
  assign bus.m_data  = m_data_r;
  assign bus.m_sat   = m_sat_r;

  conv_round_sat #(
    .ACC_W   (ACC_W),
    .OUT_W   (OUT_W),
    .SHIFT_W (SHIFT_W)
  ) u_round_sat (
    .acc    (acc),
    .shift  (shift_r),
    .sat_in (sat_acc),
    .data   (rs_data),
    .sat    (rs_sat)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= IDLE;
      len_r     <= '0;
      num_r     <= '0;
      shift_r   <= '0;
      bias_r    <= '0;
      acc       <= '0;
      beat_cnt  <= '0;
      out_cnt   <= '0;
      sat_acc   <= 1'b0;
      s_ready_r <= 1'b0;
      m_valid_r <= 1'b0;
      m_data_r  <= '0;
      m_sat_r   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_len != '0 && cfg_num != '0) begin
              len_r     <= cfg_len;
              num_r     <= cfg_num;
              // out-of-range shifts collapse to the largest meaningful one
              shift_r   <= (32'(cfg_shift) >= ACC_W) ? SHIFT_W'(ACC_W - 1) : cfg_shift;
              bias_r    <= cfg_bias;
              acc       <= cfg_bias;
              beat_cnt  <= '0;
              out_cnt   <= '0;
              sat_acc   <= 1'b0;
              s_ready_r <= 1'b1;
              busy      <= 1'b1;
              state     <= ACC;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ACC: begin
          if (s_hs) begin
            if (sum[ACC_W]) begin
              acc     <= '1;
              sat_acc <= 1'b1;
            end else begin
              acc <= sum[ACC_W-1:0];
            end
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (beat_cnt == len_r - CNT_W'(1)) begin
              s_ready_r <= 1'b0;
              state     <= RND;
            end
          end
        end
        RND: begin
          m_data_r  <= rs_data;
          m_sat_r   <= rs_sat;
          m_valid_r <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (bus.m_ready) begin
            m_valid_r <= 1'b0;
            if (out_cnt == num_r - CNT_W'(1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              out_cnt   <= out_cnt + CNT_W'(1);
              acc       <= bias_r;
              beat_cnt  <= '0;
              sat_acc   <= 1'b0;
              s_ready_r <= 1'b1;
              state     <= ACC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_acc_requant.sv
// tb_conv_acc_requant: scoreboard bench for conv_acc_requant. Expected
// activations come from a behavioural model evaluated when each job is
// issued; a monitor pops and compares them at every output handshake.
module tb_conv_acc_requant;
  import conv_acc_pkg::*;

  localparam longint unsigned AMAX = (64'd1 << 40) - 64'd1;

  logic        ap_clk   = 1'b0;
  logic        ap_rst_n = 1'b1;
  logic        start    = 1'b0;
  logic        start32  = 1'b0;
  logic [15:0] cfg_len  = '0;
  logic [15:0] cfg_num  = '0;
  logic [5:0]  cfg_shift = '0;
  logic [39:0] cfg_bias = '0;
  logic [31:0] cfg_bias32 = '0;
  logic        busy, done, err;
  logic        busy32, done32, err32;

  always #5 ap_clk = ~ap_clk;

  conv_acc_requant_if #(.PROD_W(29), .OUT_W(8)) bus ();
  conv_acc_requant_if #(.PROD_W(29), .OUT_W(8)) bus32 ();

  conv_acc_requant #(.PROD_W(29), .ACC_W(40), .OUT_W(8), .CNT_W(16)) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .start     (start),
    .cfg_len   (cfg_len),
    .cfg_num   (cfg_num),
    .cfg_shift (cfg_shift),
    .cfg_bias  (cfg_bias),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  conv_acc_requant #(.PROD_W(29), .ACC_W(32), .OUT_W(8), .CNT_W(16)) dut32 (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .start     (start32),
    .cfg_len   (cfg_len),
    .cfg_num   (cfg_num),
    .cfg_shift (cfg_shift),
    .cfg_bias  (cfg_bias32),
    .bus       (bus32),
    .busy      (busy32),
    .done      (done32),
    .err       (err32)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  logic [8:0]      exp_q[$];
  longint unsigned prod_q[$];

  // monitor: scoreboard compare on handshake, stability while stalled
  logic       held_v = 1'b0;
  logic [8:0] held;
  logic [8:0] e;
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v && bus.m_valid) check("hold", 64'({bus.m_sat, bus.m_data}), 64'(held));
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_nonempty", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("m_data", 64'(bus.m_data), 64'(e[7:0]));
          check("m_sat", 64'(bus.m_sat), 64'(e[8]));
        end
        held_v = 1'b0;
      end else if (bus.m_valid) begin
        held_v = 1'b1;
        held   = {bus.m_sat, bus.m_data};
      end else begin
        held_v = 1'b0;
      end
    end
  end

  // downstream ready: always, or one cycle in three
  int          rdy_mode = 0;
  int unsigned rcnt = 0;
  initial bus.m_ready = 1'b1;
  always @(posedge ap_clk) begin
    #1;
    rcnt++;
    bus.m_ready = (rdy_mode == 0) || (rcnt % 3 == 0);
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic push_model(input int len, input int num, input longint unsigned bias, input int sh);
    longint unsigned acc, r, q;
    int s;
    logic sat;
    s = (sh >= 40) ? 39 : sh;
    for (int px = 0; px < num; px++) begin
      acc = bias;
      sat = 1'b0;
      for (int b = 0; b < len; b++) begin
        acc = acc + prod_q[px*len + b];
        if (acc > AMAX) begin
          acc = AMAX;
          sat = 1'b1;
        end
      end
      r = acc + ((s != 0) ? (64'd1 << (s - 1)) : 64'd0);
      q = r >> s;
      if (q > 64'd255) exp_q.push_back({1'b1, 8'hff});
      else             exp_q.push_back({sat, q[7:0]});
    end
  endtask

  task automatic do_start(input logic [15:0] len, input logic [15:0] num,
                          input logic [39:0] bias, input logic [5:0] sh);
    cfg_len   = len;
    cfg_num   = num;
    cfg_bias  = bias;
    cfg_shift = sh;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic send_beat(input longint unsigned p);
    int n;
    bus.s_valid = 1'b1;
    bus.s_data  = 29'(p);
    n = 0;
    forever begin
      @(negedge ap_clk);
      if (bus.s_ready) break;
      n++;
      if (n > 50) begin
        check("s_ready_timeout", 64'(bus.s_ready), 64'd1);
        break;
      end
    end
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    forever begin
      @(negedge ap_clk);
      if (done || n > 500) break;
      n++;
    end
    check("done", 64'(done), 64'd1);
    @(negedge ap_clk);
    check("done_pulse", 64'(done), 64'd0);
    check("busy_after", 64'(busy), 64'd0);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  task automatic job(input int len, input int num, input longint unsigned bias,
                     input int sh, input int gap_at, input bit poke);
    int idx;
    push_model(len, num, bias, sh);
    do_start(16'(len), 16'(num), 40'(bias), 6'(sh));
    idx = 0;
    for (int px = 0; px < num; px++) begin
      for (int b = 0; b < len; b++) begin
        if (idx == gap_at) repeat (5) tick();
        if (poke && idx == 2) begin
          cfg_len = '0;
          start   = 1'b1;
          tick();
          start   = 1'b0;
          @(negedge ap_clk);
          check("no_err_busy", 64'(err), 64'd0);
          check("still_busy", 64'(busy), 64'd1);
          tick();
        end
        send_beat(prod_q[idx]);
        idx++;
      end
      @(negedge ap_clk);
      check("lat_rnd", 64'(bus.m_valid), 64'd0);
      @(negedge ap_clk);
      check("lat_out", 64'(bus.m_valid), 64'd1);
      tick();
    end
    wait_done();
    prod_q.delete();
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},    64'(busy), 64'd0);
    check({tag, "_s_ready"}, 64'(bus.s_ready), 64'd0);
    check({tag, "_m_valid"}, 64'(bus.m_valid), 64'd0);
    check({tag, "_m_data"},  64'(bus.m_data), 64'd0);
    check({tag, "_m_sat"},   64'(bus.m_sat), 64'd0);
    check({tag, "_done"},    64'(done), 64'd0);
    check({tag, "_err"},     64'(err), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus32.s_valid = 1'b0;
    bus32.s_data  = '0;
    bus32.m_ready = 1'b1;
    #2 ap_rst_n = 1'b0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check_idle_zero("rst");
    tick();
    ap_rst_n = 1'b1;
    tick();

    // round half up: 5 -> 3, 4 -> 2
    prod_q = '{5, 4};
    job(1, 2, 0, 1, -1, 1'b0);

    // abort after 3 of 9 beats
    do_start(16'd9, 16'd1, 40'd0, 6'd4);
    repeat (3) send_beat(100);
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    check_idle_zero("abort");
    tick();
    ap_rst_n = 1'b1;
    tick();

    // 9 x 20 = 180, (180+8)>>4 = 11
    for (int i = 0; i < 9; i++) prod_q.push_back(20);
    job(9, 1, 0, 4, -1, 1'b0);

    // backpressure: 35, 305 -> 255 sat, 7
    rdy_mode = 1;
    prod_q = '{10, 20, 100, 200, 1, 1};
    job(2, 3, 5, 0, -1, 1'b0);
    rdy_mode = 0;
    repeat (2) tick();

    // accumulator clamp at 2^40-1, then >>33 -> 128 with sticky sat
    prod_q = '{256};
    job(1, 1, AMAX - 64'd15, 33, -1, 1'b0);

    // shift beyond ACC_W acts as 39: (2^39 + 2^38) >> 39 = 1
    prod_q = '{0};
    job(1, 1, 64'd1 << 39, 63, -1, 1'b0);

    // zero-field starts raise err only
    do_start(16'd0, 16'd1, 40'd0, 6'd0);
    @(negedge ap_clk);
    check("err_len", 64'(err), 64'd1);
    check("err_len_busy", 64'(busy), 64'd0);
    check("err_len_rdy", 64'(bus.s_ready), 64'd0);
    @(negedge ap_clk);
    check("err_len_pulse", 64'(err), 64'd0);
    tick();
    do_start(16'd1, 16'd0, 40'd0, 6'd0);
    @(negedge ap_clk);
    check("err_num", 64'(err), 64'd1);
    check("err_num_busy", 64'(busy), 64'd0);
    check("err_num_rdy", 64'(bus.s_ready), 64'd0);
    @(negedge ap_clk);
    check("err_num_pulse", 64'(err), 64'd0);
    tick();

    // start while busy plus a 5-cycle s_valid gap mid-pixel
    prod_q = '{7, 9, 11, 13, 50, 60, 70, 80};
    job(4, 2, 3, 2, 5, 1'b1);

    // 32-bit accumulator build: 0xFFFF_FFF0 + 0x100 clamps
    cfg_len    = 16'd1;
    cfg_num    = 16'd1;
    cfg_shift  = 6'd0;
    cfg_bias32 = 32'hFFFF_FFF0;
    start32    = 1'b1;
    tick();
    start32    = 1'b0;
    bus32.s_valid = 1'b1;
    bus32.s_data  = 29'h100;
    n = 0;
    forever begin
      @(negedge ap_clk);
      if (bus32.s_ready || n > 50) break;
      n++;
    end
    check("acc32_s_ready", 64'(bus32.s_ready), 64'd1);
    tick();
    bus32.s_valid = 1'b0;
    n = 0;
    forever begin
      @(negedge ap_clk);
      if (bus32.m_valid || n > 50) break;
      n++;
    end
    check("acc32_m_valid", 64'(bus32.m_valid), 64'd1);
    check("acc32_m_data", 64'(bus32.m_data), 64'd255);
    check("acc32_m_sat", 64'(bus32.m_sat), 64'd1);
    @(negedge ap_clk);
    check("acc32_done", 64'(done32), 64'd1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/conv_acc_requant.md
Name: conv_acc_requant

Overview:
- Downstream stage of the conv core's unsigned 8b x 21b multiplier.
- Consumes its 29-bit unsigned products as a valid/ready stream and accumulates cfg_len products per output pixel, starting from a bias.
- Rounds, right-shifts and saturates each sum to an OUT_W-bit unsigned activation, then emits cfg_num activations per start command on a valid/ready output stream.

Parameters:
PROD_W, 29, product width (matches multiplier dout_WIDTH)
ACC_W, 40, accumulator width
OUT_W, 8, output activation width
CNT_W, 16, width of length/count fields

Ports:
ap_clk  in  1  clock, all logic on rising edge
ap_rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle command pulse; sampled only in IDLE
cfg_len  in  CNT_W  products per output (must be nonzero)
cfg_num  in  CNT_W  outputs per command (must be nonzero)
cfg_shift  in  6  right-shift amount, 0..ACC_W-1
cfg_bias  in  ACC_W  unsigned initial accumulator value
s_valid  in  1  product valid
s_ready  out  1  product accepted when s_valid && s_ready
s_data  in  PROD_W  unsigned product
m_valid  out  1  activation valid
m_ready  in  1  downstream accept
m_data  out  OUT_W  activation
m_sat  out  1  this activation was clipped (accumulator or output saturation)
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the last activation handshake
err  out  1  one-cycle pulse on start with cfg_len==0 or cfg_num==0

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all internal registers 0.
- Reset asserted mid-operation aborts immediately; partial sums are discarded and no output is emitted.
- FSM states: IDLE, ACC, RND, OUT.
- IDLE:
  - s_ready=0, m_valid=0.
  - start with cfg_len!=0 and cfg_num!=0: latch len/num/shift/bias; acc<=bias; beat_cnt<=0; out_cnt<=0; sat_acc<=0; go to ACC.
  - start with a zero field: err=1 for one cycle; remain in IDLE.
- ACC:
  - s_ready=1.
  - Each handshake: acc<=acc+zero-extended s_data; beat_cnt++.
  - On overflow of ACC_W, acc clamps to all-ones and sat_acc is set (sticky for this pixel).
  - The handshake with beat_cnt==len-1 moves to RND.
  - s_valid low: hold state; no bubble penalty.
- RND (one cycle, s_ready=0):
  - r = acc + (shift ? 1<<(shift-1) : 0), computed in ACC_W+1 bits; q = r >> shift.
  - q > 2^OUT_W-1: m_data<=all-ones and m_sat<=1.
  - Otherwise: m_data<=q[OUT_W-1:0] and m_sat<=sat_acc.
  - Go to OUT.
- OUT:
  - m_valid=1; m_data and m_sat held stable until m_ready.
  - On handshake, if out_cnt==num-1: go to IDLE; done=1 in the following cycle.
  - Otherwise: out_cnt++; acc<=bias; beat_cnt<=0; sat_acc<=0; go to ACC.
- Latency: last product handshake at cycle t gives m_valid high at t+2 (RND at t+1). Throughput is len+2 cycles per activation with m_ready tied high.
- s_ready is low during RND/OUT, so no product is ever consumed across pixel boundaries.
- start outside IDLE is ignored; err is not raised.
- cfg_len==1 is legal: ACC lasts one beat.
- cfg_shift>=ACC_W behaves as shift=ACC_W-1.

Decomposition:
- Package conv_acc_pkg holds:
  - the FSM state enum;
  - default widths PROD_W/ACC_W/OUT_W/CNT_W;
  - the SHIFT_W=6 constant.
- One sub-module, conv_round_sat: purely combinational acc/shift -> data/sat, instantiated in RND with its output registered.
- FSM and counters stay in the top level.

Test Plan:
- Reset mid-ACC after 3 of 9 beats -> all outputs 0; a new start then produces a correct result unaffected by the aborted partial sum.
- len=9, num=1, bias=0, shift=4, products all 20 -> sum 180, (180+8)>>4=11; m_data=11, m_sat=0; m_valid exactly 2 cycles after the 9th beat; done pulses after the handshake.
- len=2, num=3, bias=5, shift=0, products (10,20),(100,200),(1,1) -> m_data 35, 255 with m_sat=1 (305 clipped), 7; m_ready toggled 1-of-3 cycles, data held stable while stalled; done pulses once.
- shift=1, sums 5 and 4 -> 3 and 2, confirming round-half-up.
- ACC_W=32 build, bias=0xFFFF_FFF0, product 0x100 -> accumulator clamps, m_sat=1, m_data=255.
- start with cfg_len=0, then separately cfg_num=0 -> err pulses once per attempt; busy stays 0; s_ready stays 0.
- start pulsed while busy -> ignored and current job unaffected; s_valid held low for 5 cycles mid-ACC -> result identical to the unstalled run.
